// File: rtl/polar_pkg.sv
// rtl/polar_pkg.sv - shared polar code types and helpers
//
// Purpose: controller state encoding shared by the polar encoder and
// decoder controllers, plus a constant log2 helper for sizing stage and
// position counters.
// Ports: none (package).

package polar_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    ENC  = 2'd2,
    OUT  = 2'd3
  } polar_state_t;

  // Ceiling log2; a power-of-two argument yields the exact exponent.
  function automatic int polar_log2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/polar_butterfly_stage.sv
// rtl/polar_butterfly_stage.sv - one in-place XOR butterfly stage of F^{(x)n}
//
// Purpose: applies butterfly stage "stage" to the N-bit vector u_in. For
// every index i whose bit "stage" is 0, u_out[i] = u_in[i] ^ u_in[i + 2^stage];
// all other bits pass through unchanged. Purely combinational.
// Ports:
//   u_in   in  N      vector before the stage
//   stage  in  LOG2N  stage index, 0..LOG2N-1
//   u_out  out N      vector after the stage

module polar_butterfly_stage
  import polar_pkg::*;
#(
  parameter int N     = 64,
  parameter int LOG2N = polar_log2(N)
) (
  input  logic [N-1:0]     u_in,
  input  logic [LOG2N-1:0] stage,
  output logic [N-1:0]     u_out
);

  always_comb begin
    u_out = u_in;
    for (int s = 0; s < LOG2N; s++) begin
      if (stage == LOG2N'(s)) begin
        for (int i = 0; i < N; i++) begin
          // Partner index i | span equals i + span when bit s of i is clear,
          // and stays in range for every i, so no bounds special-casing.
          if (((i >> s) & 1) == 0) begin
            u_out[i] = u_in[i] ^ u_in[i | (1 << s)];
          end
        end
      end
    end
  end

endmodule

// File: rtl/polar_encoder_seq.sv
// rtl/polar_encoder_seq.sv - sequential polar encoder, x = u * F^{(x)n}
//
// Purpose: latches a frozen-bit mask, fills the source vector u one
// position per cycle (frozen positions forced to 0, info positions taken
// from the in_bit stream), runs LOG2N butterfly stages one per cycle and
// presents the codeword in natural order until the downstream accepts it.
// Ports:
//   clk, rst_n           clock, synchronous active-low reset
//   start, frozen_mask   begin a codeword (IDLE only); mask bit i = 1 freezes u[i]
//   busy                 high whenever the controller is not IDLE
//   in_bit, in_valid     information bit stream
//   in_ready             bit consumed when in_valid && in_ready
//   cw_data, cw_valid    codeword, bit i = x_i
//   cw_ready             downstream accepts the codeword

module polar_encoder_seq
  import polar_pkg::*;
#(
  parameter int N     = 64,
  parameter int LOG2N = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [N-1:0] frozen_mask,
  output logic         busy,
  input  logic         in_bit,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [N-1:0] cw_data,
  output logic         cw_valid,
  input  logic         cw_ready
);

  localparam logic [LOG2N-1:0] POS_LAST   = LOG2N'(N - 1);
  localparam logic [LOG2N-1:0] STAGE_LAST = LOG2N'(LOG2N - 1);

  polar_state_t     state;
  logic [N-1:0]     mask;
  logic [N-1:0]     u;
  logic [N-1:0]     u_next;
  logic [LOG2N-1:0] pos;
  logic [LOG2N-1:0] stage;
  logic             pos_frozen;
  logic             pos_done;

  polar_butterfly_stage #(
    .N     (N),
    .LOG2N (LOG2N)
  ) u_stage (
    .u_in  (u),
    .stage (stage),
    .u_out (u_next)
  );

  // in_ready depends only on registered state, never on in_valid, so the
  // upstream source may safely derive in_valid from in_ready.
  assign pos_frozen = mask[pos];
  assign in_ready   = (state == LOAD) && !pos_frozen;
  assign pos_done   = (state == LOAD) && (pos_frozen || in_valid);
  assign busy       = (state != IDLE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      mask     <= '0;
      u        <= '0;
      pos      <= '0;
      stage    <= '0;
      cw_data  <= '0;
      cw_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            mask  <= frozen_mask;
            u     <= '0;
            pos   <= '0;
            state <= LOAD;
          end
        end

        LOAD: begin
          // u was cleared on entry, so frozen positions need no write.
          if (!pos_frozen && in_valid) begin
            u[pos] <= in_bit;
          end
          if (pos_done) begin
            if (pos == POS_LAST) begin
              stage <= '0;
              state <= ENC;
            end else begin
              pos <= pos + 1'b1;
            end
          end
        end

        ENC: begin
          u <= u_next;
          if (stage == STAGE_LAST) begin
            cw_data  <= u_next;
            cw_valid <= 1'b1;
            state    <= OUT;
          end else begin
            stage <= stage + 1'b1;
          end
        end

        OUT: begin
          // start in the handshake cycle is not seen: IDLE samples it next cycle.
          if (cw_ready) begin
            cw_valid <= 1'b0;
            state    <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_polar_encoder_seq.sv
// tb/tb_polar_encoder_seq.sv - directed self-checking bench for polar_encoder_seq (N = 8)

module tb_polar_encoder_seq;

  localparam int N = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [N-1:0] frozen_mask;
  logic         busy;
  logic         in_bit;
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] cw_data;
  logic         cw_valid;
  logic         cw_ready;

  int checks = 0;
  int errors = 0;

  polar_encoder_seq #(.N(N)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .frozen_mask (frozen_mask),
    .busy        (busy),
    .in_bit      (in_bit),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .cw_data     (cw_data),
    .cw_valid    (cw_valid),
    .cw_ready    (cw_ready)
  );

  always #5 clk = ~clk;

  // Drives one codeword: bits[p] is the info bit for position p. in_valid is
  // held low for "stall" in_ready cycles before each info bit. Returns the
  // first cw_data seen with cw_valid, the edge count from the start edge
  // (inclusive) to cw_valid, and in_ready/consumption observations.
  task automatic do_encode(input logic [N-1:0] m, input logic [N-1:0] bits,
                           input int stall, output logic [N-1:0] cw,
                           output int lat, output int ready_err,
                           output int ready_hi, output int consumed);
    int   bpos;
    int   wcnt;
    logic drv_valid;
    logic rdy;
    lat = 0; ready_err = 0; ready_hi = 0; consumed = 0;
    start = 1'b1; frozen_mask = m; in_valid = 1'b0; in_bit = 1'b0;
    @(posedge clk); lat = 1; #1;
    start = 1'b0; bpos = 0; wcnt = 0;
    while (!cw_valid && lat < 200) begin
      drv_valid = 1'b0;
      rdy = in_ready;
      if (bpos < N) begin
        if (rdy !== !m[bpos]) ready_err++;
        if (rdy) ready_hi++;
        if (!m[bpos] && wcnt >= stall) drv_valid = 1'b1;
        in_bit = bits[bpos];
      end else if (rdy) begin
        ready_err++;
      end
      in_valid = drv_valid;
      @(posedge clk); lat++;
      if (bpos < N) begin
        if (drv_valid && rdy) consumed++;
        if (m[bpos] || drv_valid) begin
          bpos++; wcnt = 0;
        end else begin
          wcnt++;
        end
      end
      #1; in_valid = 1'b0;
    end
    cw = cw_data;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; frozen_mask = '0; in_bit = 1'b0;
    in_valid = 1'b0; cw_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got %b want 0", in_ready); end
    checks++; if (cw_valid !== 1'b0) begin errors++; $display("FAIL reset_cw_valid got %b want 0", cw_valid); end
    checks++; if (cw_data !== 8'h00) begin errors++; $display("FAIL reset_cw_data got %h want 00", cw_data); end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    logic [N-1:0] cw; int lat, rerr, rhi, cons;
    cw_ready = 1'b1;
    // Frozen 0,1,2,4; info 3,5,6,7 carry 1,0,1,1.
    do_encode(8'h17, 8'hC8, 0, cw, lat, rerr, rhi, cons);
    checks++; if (cw !== 8'hA5) begin errors++; $display("FAIL basic_cw got %h want a5", cw); end
    checks++; if (lat !== 12) begin errors++; $display("FAIL basic_latency got %0d want 12", lat); end
    checks++; if (rerr !== 0) begin errors++; $display("FAIL basic_in_ready got %0d bad cycles want 0", rerr); end
    checks++; if (cons !== 4) begin errors++; $display("FAIL basic_consumed got %0d want 4", cons); end
    @(posedge clk); #1;
    checks++; if (busy !== 1'b0 || cw_valid !== 1'b0) begin errors++; $display("FAIL basic_done got busy=%b valid=%b want 0 0", busy, cw_valid); end
  endtask

  task automatic test_all_info();
    logic [N-1:0] cw; int lat, rerr, rhi, cons;
    do_encode(8'h00, 8'hFF, 0, cw, lat, rerr, rhi, cons);
    checks++; if (cw !== 8'h80) begin errors++; $display("FAIL all_info_cw got %h want 80", cw); end
    checks++; if (cons !== 8) begin errors++; $display("FAIL all_info_consumed got %0d want 8", cons); end
    checks++; if (lat !== 12) begin errors++; $display("FAIL all_info_latency got %0d want 12", lat); end
    @(posedge clk); #1;
  endtask

  task automatic test_single_info();
    logic [N-1:0] cw; int lat, rerr, rhi, cons;
    do_encode(8'h7F, 8'h80, 0, cw, lat, rerr, rhi, cons);
    checks++; if (cw !== 8'hFF) begin errors++; $display("FAIL single_cw got %h want ff", cw); end
    checks++; if (cons !== 1) begin errors++; $display("FAIL single_consumed got %0d want 1", cons); end
    @(posedge clk); #1;
  endtask

  task automatic test_all_frozen();
    logic [N-1:0] cw; int lat, rerr, rhi, cons;
    do_encode(8'hFF, 8'hFF, 0, cw, lat, rerr, rhi, cons);
    checks++; if (cw !== 8'h00) begin errors++; $display("FAIL frozen_cw got %h want 00", cw); end
    checks++; if (rhi !== 0) begin errors++; $display("FAIL frozen_in_ready got %0d high cycles want 0", rhi); end
    checks++; if (cons !== 0) begin errors++; $display("FAIL frozen_consumed got %0d want 0", cons); end
    checks++; if (lat !== 12) begin errors++; $display("FAIL frozen_latency got %0d want 12", lat); end
    @(posedge clk); #1;
  endtask

  task automatic test_stall();
    logic [N-1:0] cw; int lat, rerr, rhi, cons;
    do_encode(8'h17, 8'hC8, 3, cw, lat, rerr, rhi, cons);
    checks++; if (cw !== 8'hA5) begin errors++; $display("FAIL stall_cw got %h want a5", cw); end
    checks++; if (lat !== 24) begin errors++; $display("FAIL stall_latency got %0d want 24", lat); end
    checks++; if (rerr !== 0) begin errors++; $display("FAIL stall_in_ready got %0d bad cycles want 0", rerr); end
    checks++; if (rhi !== 16) begin errors++; $display("FAIL stall_ready_cycles got %0d want 16", rhi); end
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure();
    logic [N-1:0] cw; int lat, rerr, rhi, cons;
    cw_ready = 1'b0;
    do_encode(8'h17, 8'hC8, 0, cw, lat, rerr, rhi, cons);
    checks++; if (cw !== 8'hA5) begin errors++; $display("FAIL bp_cw got %h want a5", cw); end
    for (int k = 0; k < 10; k++) begin
      start = 1'b1; frozen_mask = 8'hFF;
      @(posedge clk); #1;
      checks++;
      if (cw_valid !== 1'b1 || cw_data !== 8'hA5 || busy !== 1'b1) begin
        errors++;
        $display("FAIL bp_hold cycle %0d got valid=%b data=%h busy=%b want 1 a5 1", k, cw_valid, cw_data, busy);
      end
    end
    // Release with start still high: the handshake cycle must not accept it.
    cw_ready = 1'b1;
    @(posedge clk); #1;
    checks++; if (busy !== 1'b0 || cw_valid !== 1'b0) begin errors++; $display("FAIL bp_release got busy=%b valid=%b want 0 0", busy, cw_valid); end
    start = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    logic [N-1:0] cw; int lat, rerr, rhi, cons;
    cw_ready = 1'b1;
    // Mid-LOAD: stuck at an info position with in_ready high.
    start = 1'b1; frozen_mask = 8'h17; in_valid = 1'b0;
    @(posedge clk); #1; start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL mid_load_ready got %b want 1", in_ready); end
    rst_n = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0 || in_ready !== 1'b0 || cw_valid !== 1'b0 || cw_data !== 8'h00) begin
      errors++;
      $display("FAIL mid_load_reset got busy=%b rdy=%b valid=%b data=%h want 0 0 0 00", busy, in_ready, cw_valid, cw_data);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    // Mid-ENC: one info bit at position 7, then one butterfly stage.
    start = 1'b1; frozen_mask = 8'h7F; in_valid = 1'b1; in_bit = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (9) @(posedge clk);
    #1; in_valid = 1'b0;
    checks++; if (busy !== 1'b1 || cw_valid !== 1'b0) begin errors++; $display("FAIL mid_enc_state got busy=%b valid=%b want 1 0", busy, cw_valid); end
    rst_n = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0 || in_ready !== 1'b0 || cw_valid !== 1'b0 || cw_data !== 8'h00) begin
      errors++;
      $display("FAIL mid_enc_reset got busy=%b rdy=%b valid=%b data=%h want 0 0 0 00", busy, in_ready, cw_valid, cw_data);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    do_encode(8'h17, 8'hC8, 0, cw, lat, rerr, rhi, cons);
    checks++; if (cw !== 8'hA5) begin errors++; $display("FAIL post_reset_cw got %h want a5", cw); end
    checks++; if (lat !== 12) begin errors++; $display("FAIL post_reset_latency got %0d want 12", lat); end
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_all_info();
    test_single_info();
    test_all_frozen();
    test_stall();
    test_backpressure();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
